dmem_arbiter: RTL and testbench

Two-port round-robin arbiter placed directly upstream of the shared 16-bit data memory in the dual-core datapath. Each core's load/store stage issues requests on its own port. The arbiter selects at most one request per cycle and drives that request onto the memory's single write-enable/address/data port. One cycle later it routes the memory's registered read data back to the requesting core. An optional lock lets a core keep exclusive ownership across a read-modify-write sequence.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arbiter_rr_pick2.sv | 26 ++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the two-port data-memory arbiter.
//   DW_DEF / AW_DEF : default data / address widths of the shared memory port
//   port_t          : 1-bit requester index (0 = core 0, 1 = core 1)
//   lock_state_e    : ownership-lock FSM states
//   mem_req_t       : one requester's access bundle at the default widths
package dmem_arb_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 8;

  typedef logic port_t;

  typedef enum logic {
    LK_IDLE,
    LK_LOCKED
  } lock_state_e;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
    logic              lock;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
//   req[1:0]  in   raw requests
//   last      in   port granted most recently
//   mask[1:0] in   per-port eligibility (cleared bits can never win)
//   gnt[1:0]  out  one-hot (or zero) grant
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  assign elig = req & mask;

  // A port wins when it is the only eligible one, or when both are eligible
  // and it was not the previous winner. The two terms are mutually exclusive,
  // so the result is at most one-hot.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pick
    assign gnt[gi] = elig[gi] & (~elig[1-gi] | (last != port_t'(gi)));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port,
// registered-output data memory.
//   clk, rst                 : clock, synchronous active-high reset
//   req/we/addr/wdata/lock 0,1: per-core request (held until granted)
//   gnt0/gnt1                : combinational grant
//   rvalid0/1, rdata0/1      : read return, one cycle after the grant edge
//   mem_wd/mem_addr/mem_din  : memory command port
//   mem_dout                 : memory registered read data
// Build option: DMEM_ARB_LOCK_EN enables the ownership lock (lock0/lock1);
// without it the lock inputs are ignored and arbitration is pure round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_wd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  logic [1:0]    req_v;
  logic [1:0]    we_v;
  logic [1:0]    lock_v;
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];

  assign req_v      = {req1, req0};
  assign we_v       = {we1, we0};
  assign lock_v     = {lock1, lock0};
  assign addr_v[0]  = addr0;
  assign addr_v[1]  = addr1;
  assign wdata_v[0] = wdata0;
  assign wdata_v[1] = wdata1;

  logic [1:0] mask;
  logic [1:0] gnt;
  logic       any_gnt;
  port_t      win;
  port_t      last_reg;

  rr_pick2 u_pick (
    .req  (req_v),
    .last (last_reg),
    .mask (mask),
    .gnt  (gnt)
  );

  assign any_gnt = |gnt;
  assign win     = gnt[1];
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];

`ifdef DMEM_ARB_LOCK_EN
  lock_state_e lock_state_reg, lock_state_next;
  port_t       lock_owner_reg, lock_owner_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_reg <= LK_IDLE;
      lock_owner_reg <= 1'b0;
    end else begin
      lock_state_reg <= lock_state_next;
      lock_owner_reg <= lock_owner_next;
    end
  end

  // Mask depends only on registered state so there is no loop through the
  // picker. While locked the non-owner is blocked even if the owner is idle.
  always_comb begin
    mask = 2'b11;
    if (rst) begin
      mask = 2'b00;
    end else if (lock_state_reg == LK_LOCKED) begin
      mask = lock_owner_reg ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    lock_state_next = lock_state_reg;
    lock_owner_next = lock_owner_reg;
    case (lock_state_reg)
      LK_IDLE: begin
        if (any_gnt && lock_v[win]) begin
          lock_state_next = LK_LOCKED;
          lock_owner_next = win;
        end
      end
      LK_LOCKED: begin
        if (gnt[lock_owner_reg] && !lock_v[lock_owner_reg]) begin
          lock_state_next = LK_IDLE;
        end
      end
      default: lock_state_next = LK_IDLE;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_v;
  assign mask        = rst ? 2'b00 : 2'b11;
`endif

  // Round-robin history and memory-side hold registers.
  logic [AW-1:0] addr_hold_reg;
  logic [DW-1:0] din_hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg      <= 1'b1;
      addr_hold_reg <= '0;
      din_hold_reg  <= '0;
    end else if (any_gnt) begin
      last_reg      <= win;
      addr_hold_reg <= addr_v[win];
      din_hold_reg  <= wdata_v[win];
    end
  end

  // With no grant the address/data buses keep their previous values so the
  // memory port does not toggle on idle cycles.
  assign mem_wd   = any_gnt & we_v[win];
  assign mem_addr = any_gnt ? addr_v[win]  : addr_hold_reg;
  assign mem_din  = any_gnt ? wdata_v[win] : din_hold_reg;

  // Read return tracking: one slot per cycle, matching the memory's
  // one-cycle registered read.
  logic  rd_pend_reg;
  port_t rd_owner_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_reg  <= 1'b0;
      rd_owner_reg <= 1'b0;
    end else begin
      rd_pend_reg  <= any_gnt & ~we_v[win];
      rd_owner_reg <= win;
    end
  end

  logic [1:0]    rvalid_v;
  logic [DW-1:0] rdata_v [2];

  // rst gates the return so a read granted just before reset never surfaces.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rvalid_v[gi] = rd_pend_reg & (rd_owner_reg == port_t'(gi)) & ~rst;
    assign rdata_v[gi]  = rvalid_v[gi] ? mem_dout : '0;
  end

  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];
  assign rdata0  = rdata_v[0];
  assign rdata1  = rdata_v[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: per-port operation queues drive the requesters,
// a reference model predicts grants and read data, and a monitor compares
// read returns against a scoreboard queue.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_wd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_wd(mem_wd), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory: single port, registered output, write-through echo.
  logic [DW-1:0] mem [256];
  logic          init_en;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;

  always @(posedge clk) begin
    if (init_en) mem[init_addr] <= init_data;
    else if (mem_wd) mem[mem_addr] <= mem_din;
    mem_dout <= mem_wd ? mem_din : mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit        idle;
    bit        we;
    bit [7:0]  addr;
    bit [15:0] wdata;
    bit        lock;
  } op_t;

  typedef struct {
    int        p;
    bit [15:0] data;
    int        cyc;
  } ret_t;

  op_t  opq0[$];
  op_t  opq1[$];
  ret_t exp_q[$];
  int   gnt_log[$];

  function automatic op_t mk_op(bit idle, bit we, bit [7:0] addr, bit [15:0] wdata, bit lock);
    op_t o;
    o.idle = idle; o.we = we; o.addr = addr; o.wdata = wdata; o.lock = lock;
    return o;
  endfunction

  function automatic bit [15:0] init_val(int a);
    bit [7:0] b;
    b = 8'(a);
    return (a == 16) ? 16'hBEEF : {b, ~b};
  endfunction

  // Reference model state.
  bit        m_last;
  bit        m_locked;
  bit        m_owner;
  bit [7:0]  m_hold_addr;
  bit [15:0] m_hold_din;
  bit [15:0] ref_mem [256];

  task automatic model_reset();
    m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0;
    m_hold_addr = '0; m_hold_din = '0;
  endtask

  task automatic drive_inputs();
    op_t o;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
    if (opq0.size() > 0 && !opq0[0].idle) begin
      o = opq0[0];
      req0 = 1; we0 = o.we; addr0 = o.addr; wdata0 = o.wdata; lock0 = o.lock;
    end
    if (opq1.size() > 0 && !opq1[0].idle) begin
      o = opq1[0];
      req1 = 1; we1 = o.we; addr1 = o.addr; wdata1 = o.wdata; lock1 = o.lock;
    end
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic run_cycle();
    bit  r[2];
    bit  idl[2];
    bit  elig[2];
    op_t o[2];
    int  win;
    drive_inputs();
    @(negedge clk);
    r[0] = opq0.size() > 0 && !opq0[0].idle;
    r[1] = opq1.size() > 0 && !opq1[0].idle;
    idl[0] = opq0.size() > 0 && opq0[0].idle;
    idl[1] = opq1.size() > 0 && opq1[0].idle;
    if (r[0]) o[0] = opq0[0];
    if (r[1]) o[1] = opq1[0];
    win = -1;
    if (!rst) begin
      elig = r;
      if (LOCK_EN && m_locked) elig[!m_owner] = 1'b0;
      if (elig[0] && elig[1]) win = m_last ? 0 : 1;
      else if (elig[0]) win = 0;
      else if (elig[1]) win = 1;
    end
    check("gnt0", 32'(gnt0), 32'(win == 0));
    check("gnt1", 32'(gnt1), 32'(win == 1));
    check("mem_wd", 32'(mem_wd), 32'(win >= 0 && o[win].we));
    if (win >= 0) begin
      check("mem_addr", 32'(mem_addr), 32'(o[win].addr));
      if (o[win].we) check("mem_din", 32'(mem_din), 32'(o[win].wdata));
    end else if (!rst) begin
      check("mem_addr_hold", 32'(mem_addr), 32'(m_hold_addr));
      check("mem_din_hold", 32'(mem_din), 32'(m_hold_din));
    end
    if (gnt0) gnt_log.push_back(0);
    if (gnt1) gnt_log.push_back(1);
    if (rst) begin
      model_reset();
    end else if (win >= 0) begin
      m_last = (win == 1);
      if (LOCK_EN) begin
        if (!m_locked && o[win].lock) begin
          m_locked = 1'b1; m_owner = (win == 1);
        end else if (m_locked && (win == int'(m_owner)) && !o[win].lock) begin
          m_locked = 1'b0;
        end
      end
      m_hold_addr = o[win].addr;
      m_hold_din  = o[win].wdata;
      if (o[win].we) ref_mem[o[win].addr] = o[win].wdata;
      else exp_q.push_back('{win, ref_mem[o[win].addr], cyc + 1});
      if (win == 0) void'(opq0.pop_front());
      else void'(opq1.pop_front());
    end
    if (idl[0]) void'(opq0.pop_front());
    if (idl[1]) void'(opq1.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((opq0.size() > 0 || opq1.size() > 0) && n < budget) begin
      run_cycle();
      n++;
    end
    if (opq0.size() > 0 || opq1.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: %0d/%0d ops left after %0d cycles", opq0.size(), opq1.size(), budget);
      opq0.delete();
      opq1.delete();
    end
    run_cycle();
  endtask

  // Return monitor: compares rvalid/rdata on every cycle against the scoreboard.
  initial begin
    ret_t      e;
    bit        ev0, ev1;
    bit [15:0] ed;
    forever begin
      @(negedge clk);
      ev0 = 0; ev1 = 0; ed = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_chk++;
        n_err++;
        $display("FAIL stale_return: port %0d data %0h due cyc %0d", e.p, e.data, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        if (!rst) begin
          if (e.p == 0) ev0 = 1; else ev1 = 1;
          ed = e.data;
        end
      end
      check("rvalid0", 32'(rvalid0), 32'(ev0));
      check("rvalid1", 32'(rvalid1), 32'(ev1));
      check("rdata0", 32'(rdata0), ev0 ? 32'(ed) : 32'd0);
      check("rdata1", 32'(rdata1), ev1 ? 32'(ed) : 32'd0);
      if (ev0 || ev1)
        $display("read return: port %0d data %04h", ev1 ? 1 : 0, ed);
    end
  end

  initial begin
    int exp_seq[5];
    op_t o;
    rst = 1'b1;
    init_en = 1'b0; init_addr = '0; init_data = '0;
    drive_inputs();
    model_reset();
    // Preload memory while the arbiter is held in reset.
    for (int a = 0; a < 256; a++) begin
      @(posedge clk); #1;
      init_en = 1'b1; init_addr = 8'(a); init_data = init_val(a);
      ref_mem[a] = init_val(a);
    end
    @(posedge clk); #1;
    init_en = 1'b0;

    // Request present during reset: held off, then granted right after.
    opq0.push_back(mk_op(0, 0, 8'h10, 16'h0, 0));
    run_cycle();
    run_cycle();
    check("reset_pending", 32'(opq0.size()), 32'd1);
    rst = 1'b0;
    drain(20);

    // Continuous reads from both ports: strict alternation.
    for (int i = 0; i < 4; i++) begin
      opq0.push_back(mk_op(0, 0, 8'h01, 16'h0, 0));
      opq1.push_back(mk_op(0, 0, 8'h02, 16'h0, 0));
    end
    drain(40);

    // Write on port 0 and read of the same address on port 1.
    opq0.push_back(mk_op(0, 1, 8'h05, 16'h1234, 0));
    opq1.push_back(mk_op(0, 0, 8'h05, 16'h0, 0));
    drain(20);

    // Reset in the cycle after a granted read suppresses the return.
    opq0.push_back(mk_op(0, 0, 8'h20, 16'h0, 0));
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run_cycle();
    run_cycle();

    // Lock sequence: port 1 read with lock, then unlocking write; port 0 busy.
    gnt_log.delete();
    for (int i = 0; i < 3; i++) opq0.push_back(mk_op(0, 0, 8'h03, 16'h0, 0));
    opq1.push_back(mk_op(0, 0, 8'h04, 16'h0, 1));
    opq1.push_back(mk_op(0, 1, 8'h04, 16'hCAFE, 0));
    drain(40);
    if (LOCK_EN) begin
      exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 1; exp_seq[3] = 0; exp_seq[4] = 0;
    end else begin
      exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1; exp_seq[4] = 0;
    end
    check("lock_seq_len", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("lock_seq[%0d]", i), (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));

    // Randomized traffic on a small address window to create hazards.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 200; i++) begin
        o = mk_op($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                  16'($urandom), 1'($urandom_range(0, 1)));
        if (i == 199) begin
          o.idle = 0;
          o.lock = 0;
        end
        if (p == 0) opq0.push_back(o); else opq1.push_back(o);
      end
    end
    drain(2000);
    run_cycle();
    run_cycle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
